branch_predictor_decode: RTL

- Decode-stage branch predictor; produces the prediction consumed by the fetch stage: branch_prediction_D, predicted_PC_D.
- Decodes the instruction in D; computes the B-type/JAL target; looks up a table of 2-bit saturating counters (BHT).
- BHT is trained by conditional branches resolved in E.
- Fetch redirects to predicted_PC_D when branch_prediction_D=1; E-stage recovery is handled outside this block.

---
 rtl/branch_predictor_decode.sv | 65 ++++++
 1 files changed

// File: rtl/branch_predictor_decode.sv
// branch_predictor_decode: decode-stage BHT predictor for B-type/JAL; optional BP_STATS_EN adds resolved/mispredict counters
module branch_predictor_decode #(
  parameter int INDEX_BITS = 6,
  parameter logic [1:0] COUNTER_RESET = 2'b01
) (
  input  logic        clock,
  input  logic        async_reset,
  input  logic        enable_D,
  input  logic [31:0] instruction_D,
  input  logic [31:0] PC_D,
  input  logic        update_E,
  input  logic [31:0] PC_E,
  input  logic        branch_taken_E,
  input  logic        prediction_E,
  output logic        branch_prediction_D,
  output logic [31:0] predicted_PC_D
`ifdef BP_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  logic [DEPTH-1:0][1:0] bht;
  logic [1:0] rd_ctr, cur_ctr, nxt_ctr;
  logic is_b, is_j;
  logic [31:0] imm_b, imm_j;
  logic unused;
  assign unused = ^{PC_E[31:INDEX_BITS+2], PC_E[1:0]
`ifndef BP_STATS_EN
    , prediction_E
`endif
  };
  // Decode, immediate extraction and zero-latency prediction from current table state
  always_comb begin
    is_b = instruction_D[6:0] == 7'b1100011;
    is_j = instruction_D[6:0] == 7'b1101111;
    imm_b = {{20{instruction_D[31]}}, instruction_D[7], instruction_D[30:25], instruction_D[11:8], 1'b0};
    imm_j = {{12{instruction_D[31]}}, instruction_D[19:12], instruction_D[20], instruction_D[30:21], 1'b0};
    rd_ctr = bht[PC_D[INDEX_BITS+1:2]];
    branch_prediction_D = enable_D & (is_j | (is_b & rd_ctr[1]));
    predicted_PC_D = branch_prediction_D ? PC_D + (is_j ? imm_j : imm_b) : 32'd0;
  end
  // Saturating step of the counter addressed by the resolving branch
  always_comb begin
    cur_ctr = bht[PC_E[INDEX_BITS+1:2]];
    nxt_ctr = branch_taken_E ? (cur_ctr == 2'b11 ? cur_ctr : cur_ctr + 2'd1)
                             : (cur_ctr == 2'b00 ? cur_ctr : cur_ctr - 2'd1);
  end
  // Table held in flops so the whole table clears asynchronously
  always_ff @(posedge clock or posedge async_reset)
    if (async_reset) bht <= {DEPTH{COUNTER_RESET}};
    else if (update_E) bht[PC_E[INDEX_BITS+1:2]] <= nxt_ctr;
`ifdef BP_STATS_EN
  // Saturating counts of resolved branches and of mispredictions
  always_ff @(posedge clock or posedge async_reset)
    if (async_reset) begin
      branch_count <= '0;
      mispredict_count <= '0;
    end else if (update_E) begin
      branch_count <= branch_count == '1 ? branch_count : branch_count + 32'd1;
      mispredict_count <= (prediction_E != branch_taken_E && mispredict_count != '1) ? mispredict_count + 32'd1 : mispredict_count;
    end
`endif
endmodule
